// File: rtl/program_loader_pkg.sv
// Program loader shared types: FSM states, CPU reset hold default and ISA opcodes for program images.
// LOADER_CHECKSUM_EN adds the RECV_CSUM state.
package loader_pkg;

  localparam int RST_CYCLES_DEF = 3;

  localparam logic [4:0] OP_ALU     = 5'b00000;
  localparam logic [4:0] OP_LLI     = 5'b00010;
  localparam logic [4:0] OP_LDRRI   = 5'b00011;
  localparam logic [4:0] OP_LDRRR   = 5'b00100;
  localparam logic [4:0] OP_OUT_HLT = 5'b11100;

  typedef enum logic [2:0] {
    IDLE,
    RECV_HI,
    RECV_LO,
    WRITE,
    RST_CPU,
    RUN
`ifdef LOADER_CHECKSUM_EN
    , RECV_CSUM
`endif
  } state_t;

endpackage

// File: rtl/program_loader_byte_pair_packer.sv
// Assembles two stream bytes (high first) into a 16-bit word; word_vld pulses the cycle after the low byte.
// in_ready rises on start and drops after the low byte, so nothing is consumed until the next start.
module byte_pair_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] word_dat,
  output logic        word_vld
);

  logic lo_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      lo_phase <= 1'b0;
      word_dat <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (start) begin
        in_ready <= 1'b1;
        lo_phase <= 1'b0;
      end else if (in_ready && in_valid) begin
        if (!lo_phase) begin
          word_dat[15:8] <= in_byte;
          lo_phase       <= 1'b1;
        end else begin
          word_dat[7:0] <= in_byte;
          lo_phase      <= 1'b0;
          in_ready      <= 1'b0;
          word_vld      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams bytes into the CPU memory loader port, holds the CPU in reset RST_CYCLES cycles, then runs it until Done.
// One word per 3 cycles with back-to-back bytes; In_Ready low outside receive states. Optional LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              Load_Start,
  input  logic [ADDR_W-1:0] Load_Base,
  input  logic [ADDR_W:0]   Load_Count,
  input  logic [7:0]        In_Byte,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [ADDR_W-1:0] Tb_MEMAddr,
  output logic [15:0]       Tb_MEMData,
  output logic              Tb_MEMWE,
  output logic              TBorNot,
  output logic              CpuRst,
  input  logic              CpuDone,
  output logic              Busy,
  output logic              RunDone,
  output logic              CsumErr
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [7:0]        rst_cnt;
  logic              pk_start;
  logic              pk_rdy;
  logic              pk_vld;
  logic [15:0]       pk_dat;
  logic              byte_hs;
  logic              last_word;

  assign last_word = (remaining == (ADDR_W+1)'(1));
  assign byte_hs   = In_Valid && pk_rdy;
  assign pk_start  = (state == IDLE && Load_Start && Load_Count != '0) ||
                     (state == WRITE && !last_word);

  byte_pair_packer u_packer (
    .clk      (clk),
    .rst_n    (Rst_n),
    .start    (pk_start),
    .in_byte  (In_Byte),
    .in_valid (In_Valid),
    .in_ready (pk_rdy),
    .word_dat (pk_dat),
    .word_vld (pk_vld)
  );

  // The packer's word_vld register is high exactly in the WRITE cycle.
  assign Tb_MEMAddr = addr;
  assign Tb_MEMData = pk_dat;
  assign Tb_MEMWE   = pk_vld;

`ifdef LOADER_CHECKSUM_EN
  logic       csum_rdy;
  logic [7:0] sum;
  logic       csum_err;
  assign In_Ready = pk_rdy | csum_rdy;
  assign CsumErr  = csum_err;
`else
  assign In_Ready = pk_rdy;
  assign CsumErr  = 1'b0;
`endif

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      rst_cnt   <= '0;
      TBorNot   <= 1'b0;
      CpuRst    <= 1'b1;
      Busy      <= 1'b0;
      RunDone   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_rdy  <= 1'b0;
      sum       <= '0;
      csum_err  <= 1'b0;
`endif
    end else begin
      RunDone <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (byte_hs) sum <= sum + In_Byte;
`endif
      unique case (state)
        IDLE: if (Load_Start) begin
          addr      <= Load_Base;
          remaining <= Load_Count;
          Busy      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum       <= '0;
          csum_err  <= 1'b0;
`endif
          if (Load_Count != '0) begin
            state   <= RECV_HI;
            TBorNot <= 1'b1;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state    <= RECV_CSUM;
            csum_rdy <= 1'b1;
`else
            state    <= RST_CPU;
            rst_cnt  <= '0;
`endif
          end
        end
        RECV_HI: if (byte_hs) state <= RECV_LO;
        RECV_LO: if (byte_hs) state <= WRITE;
        WRITE: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (last_word) begin
            TBorNot <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            state    <= RECV_CSUM;
            csum_rdy <= 1'b1;
`else
            state    <= RST_CPU;
            rst_cnt  <= '0;
`endif
          end else begin
            state <= RECV_HI;
          end
        end
        RST_CPU: begin
          if (rst_cnt == 8'(RST_CYCLES - 1)) begin
            state  <= RUN;
            CpuRst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: if (CpuDone) begin
          RunDone <= 1'b1;
          CpuRst  <= 1'b1;
          Busy    <= 1'b0;
          state   <= IDLE;
        end
`ifdef LOADER_CHECKSUM_EN
        // A bad checksum abandons the run with the CPU still held in reset.
        RECV_CSUM: if (In_Valid) begin
          csum_rdy <= 1'b0;
          if (In_Byte == sum) begin
            state   <= RST_CPU;
            rst_cnt <= '0;
          end else begin
            csum_err <= 1'b1;
            Busy     <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed vector table, spec sequences and randomized loads against a write-list model.
`timescale 1ns/1ps
module tb_program_loader;
  import loader_pkg::*;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        Load_Start;
  logic [7:0]  Load_Base;
  logic [8:0]  Load_Count;
  logic [7:0]  In_Byte;
  logic        In_Valid;
  logic        In_Ready;
  logic [7:0]  Tb_MEMAddr;
  logic [15:0] Tb_MEMData;
  logic        Tb_MEMWE;
  logic        TBorNot;
  logic        CpuRst;
  logic        CpuDone;
  logic        Busy;
  logic        RunDone;
  logic        CsumErr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int fall_cyc = 0;
  int rundone_cnt = 0;
  int bad_cnt = 0;
  int csum_seen = 0;
  logic prev_rst = 1'b1;
  logic [23:0] wr_q[$];

  typedef struct {
    logic [7:0] base;
    int         count;
    int         mode;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  program_loader #(.ADDR_W(8), .RST_CYCLES(3)) dut (
    .clk(clk), .Rst_n(Rst_n), .Load_Start(Load_Start), .Load_Base(Load_Base),
    .Load_Count(Load_Count), .In_Byte(In_Byte), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Tb_MEMAddr(Tb_MEMAddr), .Tb_MEMData(Tb_MEMData), .Tb_MEMWE(Tb_MEMWE), .TBorNot(TBorNot),
    .CpuRst(CpuRst), .CpuDone(CpuDone), .Busy(Busy), .RunDone(RunDone), .CsumErr(CsumErr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (Tb_MEMWE) begin
      wr_q.push_back({Tb_MEMAddr, Tb_MEMData});
      last_we_cyc = cyc;
      if (!TBorNot || In_Ready || !CpuRst) bad_cnt = bad_cnt + 1;
    end
    if (!CpuRst && (TBorNot || !Busy || In_Ready)) bad_cnt = bad_cnt + 1;
    if (RunDone) rundone_cnt = rundone_cnt + 1;
    if (CsumErr) csum_seen = csum_seen + 1;
    if (prev_rst && !CpuRst) fall_cyc = cyc;
    prev_rst = CpuRst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: back-to-back valid, 1: valid toggles every cycle, 2: random gaps
  task automatic feed(input logic [7:0] bq[$], input int mode);
    int idx = 0;
    int budget = 5000;
    bit ph = 1'b1;
    while (idx < bq.size() && budget > 0) begin
      case (mode)
        0:       In_Valid = 1'b1;
        1:       In_Valid = ph;
        default: In_Valid = ($urandom_range(0, 2) != 0);
      endcase
      In_Byte = In_Valid ? bq[idx] : 8'($urandom);
      @(negedge clk);
      if (In_Valid && In_Ready) idx++;
      @(posedge clk);
      #1;
      ph = !ph;
      budget--;
    end
    In_Valid = 1'b0;
    check("feed_bytes_accepted", 32'(idx), 32'(bq.size()));
  endtask

  task automatic run_load(input logic [7:0] base, input int count, input int mode,
                          input logic [7:0] bq[$], input int done_delay);
    int st;
    int wb;
    int rb;
    int bb;
    int budget;
    logic [7:0] fb[$];
    wb = wr_q.size();
    rb = rundone_cnt;
    bb = bad_cnt;
    fb = bq;
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] sum;
      sum = 8'h00;
      foreach (bq[i]) sum = sum + bq[i];
      fb.push_back(sum);
    end
`endif
    Load_Base = base;
    Load_Count = 9'(count);
    Load_Start = 1'b1;
    tick(1);
    Load_Start = 1'b0;
    st = cyc;
    check("start_busy", 32'(Busy), 32'd1);
    check("start_tbornot", 32'(TBorNot), 32'(count != 0));
    check("start_cpurst", 32'(CpuRst), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    check("start_rdy", 32'(In_Ready), 32'd1);
    check("start_csum_clear", 32'(CsumErr), 32'd0);
`else
    check("start_rdy", 32'(In_Ready), 32'(count != 0));
`endif
    feed(fb, mode);
    budget = 100;
    while (fall_cyc <= st && budget > 0) begin
      tick(1);
      budget--;
    end
    check("cpu_released", 32'(fall_cyc > st), 32'd1);
    check("we_count", 32'(wr_q.size() - wb), 32'(count));
    for (int i = 0; i < count && wb + i < wr_q.size(); i++)
      check("write_addr_data", 32'(wr_q[wb + i]), 32'({8'(base + 8'(i)), bq[2*i], bq[2*i+1]}));
`ifndef LOADER_CHECKSUM_EN
    check("release_latency", 32'(fall_cyc), 32'(((count == 0) ? st : last_we_cyc) + 4));
`endif
    Load_Base = 8'h33;
    Load_Count = 9'd3;
    Load_Start = 1'b1;
    tick(1);
    Load_Start = 1'b0;
    tick(1);
    check("run_ignores_start", 32'({Busy, CpuRst, TBorNot, In_Ready}), 32'b1000);
    tick(done_delay);
    CpuDone = 1'b1;
    tick(1);
    CpuDone = 1'b0;
    check("rundone_pulse", 32'(RunDone), 32'd1);
    tick(2);
    check("rundone_count", 32'(rundone_cnt - rb), 32'd1);
    check("idle_after_done", 32'({Busy, CpuRst, TBorNot, In_Ready}), 32'b0100);
    check("protocol", 32'(bad_cnt - bb), 32'd0);
  endtask

  initial begin
    vec_t vt[5];
    logic [7:0] bq[$];
    logic [15:0] spec_w[5];
    logic [15:0] prog[9];
    int wb;
    int cnt;

    Rst_n = 1'b1; Load_Start = 1'b0; Load_Base = '0; Load_Count = '0;
    In_Byte = '0; In_Valid = 1'b0; CpuDone = 1'b0;
    #1 Rst_n = 1'b0;
    #2;
    check("rst_in_ready", 32'(In_Ready), 32'd0);
    check("rst_addr", 32'(Tb_MEMAddr), 32'd0);
    check("rst_data", 32'(Tb_MEMData), 32'd0);
    check("rst_flags", 32'({Tb_MEMWE, TBorNot, CpuRst, Busy, RunDone, CsumErr}), 32'b001000);
    @(negedge clk);
    @(negedge clk);
    Rst_n = 1'b1;
    tick(2);

    // Sequence from the first load example: explicit expected words.
    bq = '{8'h00, 8'h01, 8'h00, 8'h21, 8'h00, 8'hA0, 8'h00, 8'h0D, 8'h07, 8'h00};
    spec_w = '{16'h0001, 16'h0021, 16'h00A0, 16'h000D, 16'h0700};
    wb = wr_q.size();
    run_load(8'h80, 5, 0, bq, 5);
    if (wr_q.size() >= wb + 5) begin
      for (int i = 0; i < 5; i++)
        check("spec_word", 32'(wr_q[wb + i]), 32'({8'h80 + 8'(i), spec_w[i]}));
    end else begin
      check("spec_words_present", 32'(wr_q.size()), 32'(wb + 5));
    end

    // Small program image, CPU finishes 50 cycles after release.
    prog = '{{OP_LLI, 11'h180}, {OP_LLI, 11'h201}, {OP_LDRRI, 11'h320}, {OP_LDRRR, 11'h328},
             16'h2D1A, {OP_OUT_HLT, 11'h00C}, {OP_OUT_HLT, 11'h010}, {OP_OUT_HLT, 11'h014},
             {OP_OUT_HLT, 11'h001}};
    bq = {};
    foreach (prog[i]) begin
      bq.push_back(prog[i][15:8]);
      bq.push_back(prog[i][7:0]);
    end
    run_load(8'h00, 9, 0, bq, 50);

    // Directed table: address wrap, valid toggling, full 256-word load, random gaps.
    vt[0] = '{8'hFF, 2,   0, 8'hFF, 8'h00};
    vt[1] = '{8'h10, 2,   1, 8'h10, 8'h11};
    vt[2] = '{8'h80, 256, 0, 8'h80, 8'h7F};
    vt[3] = '{8'hFE, 4,   2, 8'hFE, 8'h01};
    vt[4] = '{8'h00, 1,   2, 8'h00, 8'h00};
    for (int v = 0; v < 5; v++) begin
      bq = {};
      for (int i = 0; i < 2 * vt[v].count; i++) bq.push_back(8'($urandom));
      wb = wr_q.size();
      run_load(vt[v].base, vt[v].count, vt[v].mode, bq, 3);
      if (wr_q.size() >= wb + vt[v].count) begin
        check("vec_first_addr", 32'(wr_q[wb][23:16]), 32'(vt[v].exp_first));
        check("vec_last_addr", 32'(wr_q[wb + vt[v].count - 1][23:16]), 32'(vt[v].exp_last));
      end else begin
        check("vec_writes_present", 32'(wr_q.size()), 32'(wb + vt[v].count));
      end
    end

    // Zero-length load goes straight to the CPU reset hold.
    bq = {};
    run_load(8'h20, 0, 0, bq, 2);

    // Asynchronous reset while waiting for the low byte.
    Load_Base = 8'h40; Load_Count = 9'd2; Load_Start = 1'b1;
    tick(1);
    Load_Start = 1'b0;
    In_Byte = 8'hA5; In_Valid = 1'b1;
    tick(1);
    In_Valid = 1'b0;
    check("recv_lo_state", 32'({In_Ready, TBorNot, Busy}), 32'b111);
    #2 Rst_n = 1'b0;
    #1;
    check("midload_rst_flags", 32'({In_Ready, Tb_MEMWE, TBorNot, CpuRst, Busy, RunDone, CsumErr}), 32'b0001000);
    check("midload_rst_addr", 32'(Tb_MEMAddr), 32'd0);
    check("midload_rst_data", 32'(Tb_MEMData), 32'd0);
    #3 Rst_n = 1'b1;
    tick(3);
    check("post_reset_idle", 32'({Busy, In_Ready, Tb_MEMWE, CpuRst}), 32'b0001);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(1, 12);
      bq = {};
      for (int i = 0; i < 2 * cnt; i++) bq.push_back(8'($urandom));
      run_load(8'($urandom), cnt, $urandom_range(0, 2), bq, $urandom_range(0, 10));
    end

`ifdef LOADER_CHECKSUM_EN
    begin
      int rb;
      rb = rundone_cnt;
      wb = wr_q.size();
      bq = '{8'h00, 8'h01, 8'h00, 8'h21, 8'h55};
      Load_Base = 8'h00; Load_Count = 9'd2; Load_Start = 1'b1;
      tick(1);
      Load_Start = 1'b0;
      feed(bq, 0);
      check("csum_err_set", 32'(CsumErr), 32'd1);
      check("csum_err_hold", 32'({CpuRst, Busy}), 32'b10);
      check("csum_err_writes", 32'(wr_q.size() - wb), 32'd2);
      tick(10);
      check("csum_err_no_release", 32'(CpuRst), 32'd1);
      check("csum_err_no_rundone", 32'(rundone_cnt - rb), 32'd0);
      bq = '{8'h00, 8'h01, 8'h00, 8'h21};
      run_load(8'h00, 2, 0, bq, 4);
    end
`else
    check("csum_err_never", 32'(csum_seen), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the multicycle RISC computer.
- Takes a byte stream over a valid/ready handshake, assembles 16-bit words high byte first, and writes them into the computer's memory through its loader port (Tb_MEMAddr/Tb_MEMData/Tb_MEMWE/TBorNot).
- Then holds the CPU in reset for 3 cycles, releases it, and waits for Done.
- Replaces the bench-driven load/reset sequence so the computer can be programmed in hardware.

Parameters:
- ADDR_W, 8, memory word-address width; Load_Count is ADDR_W+1 bits.
- RST_CYCLES, 3, number of cycles CpuRst is held after the last write, before release.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Load_Start  in  1  one-cycle start request; sampled only in IDLE.
- Load_Base  in  ADDR_W  first memory address; captured on Load_Start.
- Load_Count  in  ADDR_W+1  number of words, 0..256; captured on Load_Start.
- In_Byte  in  8  stream byte.
- In_Valid  in  1  In_Byte valid.
- In_Ready  out  1  loader accepts In_Byte this cycle.
- Tb_MEMAddr  out  ADDR_W  memory write address.
- Tb_MEMData  out  16  memory write data.
- Tb_MEMWE  out  1  memory write enable.
- TBorNot  out  1  selects the loader port over the CPU memory path.
- CpuRst  out  1  drives the computer Rst input (active-high).
- CpuDone  in  1  computer Done.
- Busy  out  1  high in every state except IDLE.
- RunDone  out  1  one-cycle pulse when CpuDone is seen in RUN.
- CsumErr  out  1  sticky checksum error (see Optional Feature); cleared on the next Load_Start.

Behaviour:
- Reset values: state=IDLE, In_Ready=0, Tb_MEMAddr=0, Tb_MEMData=0, Tb_MEMWE=0, TBorNot=0, CpuRst=1, Busy=0, RunDone=0, CsumErr=0.
- All outputs are registered.
- States: IDLE, RECV_HI, RECV_LO, WRITE, RST_CPU, RUN.
- IDLE:
  - Load_Start=1 captures addr=Load_Base and remaining=Load_Count.
  - If Load_Count!=0, go to RECV_HI; else go to RST_CPU.
  - CpuRst=1 in IDLE.
- RECV_HI:
  - In_Ready=1.
  - On In_Valid&&In_Ready, latch data[15:8] and go to RECV_LO.
- RECV_LO:
  - In_Ready=1.
  - On the handshake, latch data[7:0] and go to WRITE.
- WRITE:
  - Exactly one cycle: Tb_MEMWE=1, Tb_MEMAddr=addr, Tb_MEMData=data, In_Ready=0.
  - Then addr += 1 (mod 2^ADDR_W, wrapping 255 to 0) and remaining -= 1.
  - Go to RECV_HI if remaining != 0 after the decrement; otherwise go to RST_CPU.
- TBorNot=1 from entry to RECV_HI through the WRITE cycle of the last word; 0 elsewhere.
- Throughput: a word accepted on back-to-back valid bytes takes 3 cycles (HI, LO, WRITE).
- RST_CPU: CpuRst=1 and TBorNot=0 for RST_CYCLES cycles, then go to RUN.
- RUN:
  - CpuRst=0.
  - On CpuDone=1, pulse RunDone for 1 cycle and return to IDLE, which reasserts CpuRst.
- CpuRst=1 in every state except RUN.
- Load_Start outside IDLE is ignored.
- In_Valid with In_Ready=0 is ignored; no byte is consumed.
- Rst_n low mid-load: immediate return to reset values. Partially written memory is left as-is; no rollback.
- Load_Count=256 with Load_Base=h80 writes h80..hFF, then h00..h7F.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - An extra state RECV_CSUM follows the last WRITE (In_Ready=1, TBorNot=0).
  - It accepts one byte that must equal the 8-bit modulo-256 sum of all payload bytes.
  - Match: go to RST_CPU.
  - Mismatch: set CsumErr=1 and go to IDLE without releasing the CPU (RunDone is never pulsed).
  - Load_Count=0 still expects a checksum byte of h00.
- When not defined: no RECV_CSUM state, no sum register, CsumErr tied to 0.

Decomposition:
- Package loader_pkg holds:
  - state enum;
  - RST_CYCLES default;
  - ISA opcode constants (LLI=5'b00010, LDRri=5'b00011, LDRrr=5'b00100, ALU=5'b00000, OUT/HLT=5'b11100) for bench program encoding.
- One natural sub-module, byte_pair_packer: the RECV_HI/RECV_LO handshake and 16-bit assembly, emitting a word_valid pulse.

Test Plan:
- Load_Base=h80, Load_Count=5, bytes 00 01 00 21 00 A0 00 0D 07 00 -> five WE pulses with addr/data h80/0001, h81/0021, h82/00A0, h83/000D, h84/0700; then CpuRst high for 3 cycles, then low.
- Load_Base=h00, Count=9, program words 1180,1201,1B20,2328,2D1A,E00C,E010,E014,E001, then CpuDone asserted 50 cycles later -> RunDone pulses once; state IDLE; CpuRst=1.
- In_Valid toggled 1/0 every cycle during a 2-word load -> each byte accepted only on valid cycles; exactly 2 WE pulses; data unchanged.
- Load_Base=hFF, Count=2 -> writes at hFF then h00 (wrap).
- Count=0 -> no WE pulse; RST_CPU entered 1 cycle after Load_Start; Load_Start during RUN is ignored.
- Rst_n pulled low during RECV_LO -> asynchronous return to reset values.
- With LOADER_CHECKSUM_EN: a wrong checksum byte sets CsumErr and CpuRst stays 1; the correct byte h22 for payload 00 01 00 21 releases the CPU.
